mem_bank_xbar_sram: RTL and testbench

- Multi-port, word-interleaved banked SRAM subsystem for memory tiles; generalised successor of the single-port, row-selected SRAM bank array behind the SRAM shim.
- NumPorts simple req/gnt/rvalid managers, e.g. the sram shim plus a DMA-side port, access NumBanks interleaved banks; each bank is built from NumBankRows tc_sram macros.
- Per-bank round-robin arbitration; fixed, parametrised read latency; in-order responses per port.

---
 rtl/mem_bank_xbar_pkg.sv | 34 +++
 rtl/mem_bank_rr_arb.sv | 45 ++++
 rtl/mem_bank_xbar_sram.sv | 204 ++++++++++++++++++++
 tb/tb_mem_bank_xbar_sram.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bank_xbar_pkg.sv
// Shared helpers for the banked SRAM crossbar: address-field placement within a byte address.
package mem_bank_xbar_pkg;

    typedef enum logic [1:0] {FieldBank, FieldWord, FieldRow} addr_field_e;

    // Bit offset of a select field: byte offset, then bank, then word, then row.
    function automatic int unsigned field_off(input int unsigned data_width,
                                              input int unsigned num_banks,
                                              input int unsigned sram_num_words,
                                              input addr_field_e field);
        int unsigned off;
        off = $clog2(data_width / 8);
        if (field != FieldBank) off = off + $clog2(num_banks);
        if (field == FieldRow) off = off + $clog2(sram_num_words);
        return off;
    endfunction

    function automatic int unsigned field_width(input int unsigned num_banks,
                                                input int unsigned sram_num_words,
                                                input int unsigned num_bank_rows,
                                                input addr_field_e field);
        case (field)
            FieldBank: return $clog2(num_banks);
            FieldWord: return $clog2(sram_num_words);
            default:   return $clog2(num_bank_rows);
        endcase
    endfunction

    // Storage width for a select field that may be zero bits wide.
    function automatic int unsigned sel_width(input int unsigned bits);
        return (bits > 0) ? bits : 1;
    endfunction

endpackage

// File: rtl/mem_bank_rr_arb.sv
// Round-robin arbiter for one bank; the priority pointer moves past the winner only on a grant.
module mem_bank_rr_arb #(
    parameter int unsigned NumPorts = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumPorts-1:0] req_i,
    output logic [NumPorts-1:0] gnt_o
);

    localparam int unsigned PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    logic [PtrW-1:0] ptr_q, ptr_d;
    logic            found;

    // Two passes: ports at or above the pointer first, then wrap around from port 0.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            if (!found && req_i[p] && (p >= 32'(ptr_q))) begin
                gnt_o[p] = 1'b1;
                found    = 1'b1;
                ptr_d    = (p == NumPorts - 1) ? '0 : PtrW'(p + 1);
            end
        end
        for (int unsigned p = 0; p < NumPorts; p++) begin
            if (!found && req_i[p]) begin
                gnt_o[p] = 1'b1;
                found    = 1'b1;
                ptr_d    = (p == NumPorts - 1) ? '0 : PtrW'(p + 1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_bank_xbar_sram.sv
// Multi-port word-interleaved banked SRAM with per-bank round-robin arbitration.
// Define MEM_BANK_XBAR_CONFLICT_CNT_EN to add per-bank saturating conflict counters.
module mem_bank_xbar_sram import mem_bank_xbar_pkg::*; #(
    parameter int unsigned NumPorts     = 2,
    parameter int unsigned NumBanks     = 4,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned SramNumWords = 512,
    parameter int unsigned NumBankRows  = 2,
    parameter int unsigned SramLatency  = 1,
    parameter int unsigned AddrWidth    = 48
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumPorts-1:0]                  req_i,
    output logic [NumPorts-1:0]                  gnt_o,
    input  logic [NumPorts-1:0]                  we_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0]   addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]   wdata_i,
    input  logic [NumPorts-1:0][DataWidth/8-1:0] be_i,
    output logic [NumPorts-1:0]                  rvalid_o,
    output logic [NumPorts-1:0][DataWidth-1:0]   rdata_o
`ifdef MEM_BANK_XBAR_CONFLICT_CNT_EN
    ,
    output logic [NumBanks-1:0][31:0]            conflict_cnt_o
`endif
);

    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned BankOff  = field_off(DataWidth, NumBanks, SramNumWords, FieldBank);
    localparam int unsigned WordOff  = field_off(DataWidth, NumBanks, SramNumWords, FieldWord);
    localparam int unsigned RowOff   = field_off(DataWidth, NumBanks, SramNumWords, FieldRow);
    localparam int unsigned BankBits = field_width(NumBanks, SramNumWords, NumBankRows, FieldBank);
    localparam int unsigned WordBits = field_width(NumBanks, SramNumWords, NumBankRows, FieldWord);
    localparam int unsigned RowBits  = field_width(NumBanks, SramNumWords, NumBankRows, FieldRow);
    localparam int unsigned BankW    = sel_width(BankBits);
    localparam int unsigned WordW    = sel_width(WordBits);
    localparam int unsigned RowW     = sel_width(RowBits);

    typedef struct packed {
        logic            valid;
        logic            we;
        logic [BankW-1:0] bank;
        logic [RowW-1:0]  row;
    } resp_meta_t;

    logic [NumPorts-1:0][BankW-1:0] port_bank;
    logic [NumPorts-1:0][WordW-1:0] port_word;
    logic [NumPorts-1:0][RowW-1:0]  port_row;
    logic                           unused_addr;

    // Bits above the row field are ignored, so addresses alias.
    assign unused_addr = ^addr_i;

    always_comb begin
        port_bank = '0;
        port_word = '0;
        port_row  = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            if (BankBits > 0) port_bank[p] = addr_i[p][BankOff +: BankW];
            if (WordBits > 0) port_word[p] = addr_i[p][WordOff +: WordW];
            if (RowBits > 0)  port_row[p]  = addr_i[p][RowOff +: RowW];
        end
    end

    logic [NumBanks-1:0][NumPorts-1:0] bank_req, bank_gnt;

    always_comb begin
        bank_req = '0;
        for (int unsigned b = 0; b < NumBanks; b++) begin
            for (int unsigned p = 0; p < NumPorts; p++) begin
                bank_req[b][p] = req_i[p] && !rst_i && (port_bank[p] == BankW'(b));
            end
        end
    end

    for (genvar b = 0; b < NumBanks; b++) begin : g_arb
        mem_bank_rr_arb #(
            .NumPorts(NumPorts)
        ) u_arb (
            .clk_i(clk_i),
            .rst_i(rst_i),
            .req_i(bank_req[b]),
            .gnt_o(bank_gnt[b])
        );
    end

    always_comb begin
        gnt_o = '0;
        for (int unsigned b = 0; b < NumBanks; b++) begin
            gnt_o = gnt_o | bank_gnt[b];
        end
    end

    logic [NumBanks-1:0]                bank_act;
    logic [NumBanks-1:0]                bank_we;
    logic [NumBanks-1:0][WordW-1:0]     bank_word;
    logic [NumBanks-1:0][RowW-1:0]      bank_row;
    logic [NumBanks-1:0][DataWidth-1:0] bank_wdata;
    logic [NumBanks-1:0][BeWidth-1:0]   bank_be;

    always_comb begin
        bank_act   = '0;
        bank_we    = '0;
        bank_word  = '0;
        bank_row   = '0;
        bank_wdata = '0;
        bank_be    = '0;
        for (int unsigned b = 0; b < NumBanks; b++) begin
            for (int unsigned p = 0; p < NumPorts; p++) begin
                if (bank_gnt[b][p]) begin
                    bank_act[b]   = 1'b1;
                    bank_we[b]    = we_i[p];
                    bank_word[b]  = port_word[p];
                    bank_row[b]   = port_row[p];
                    bank_wdata[b] = wdata_i[p];
                    bank_be[b]    = be_i[p];
                end
            end
        end
    end

    // tc_sram macro behaviour: byte-masked write, read data delayed SramLatency cycles and held.
    logic [DataWidth-1:0] mem_q        [NumBanks][NumBankRows][SramNumWords];
    logic [DataWidth-1:0] sram_rdata_q [NumBanks][NumBankRows][SramLatency];

    always_ff @(posedge clk_i) begin
        for (int unsigned b = 0; b < NumBanks; b++) begin
            for (int unsigned r = 0; r < NumBankRows; r++) begin
                if (bank_act[b] && (bank_row[b] == RowW'(r))) begin
                    if (bank_we[b]) begin
                        for (int unsigned i = 0; i < BeWidth; i++) begin
                            if (bank_be[b][i]) begin
                                mem_q[b][r][bank_word[b]][i*8 +: 8] <= bank_wdata[b][i*8 +: 8];
                            end
                        end
                    end else begin
                        sram_rdata_q[b][r][0] <= mem_q[b][r][bank_word[b]];
                    end
                end
                for (int unsigned s = 1; s < SramLatency; s++) begin
                    sram_rdata_q[b][r][s] <= sram_rdata_q[b][r][s-1];
                end
            end
        end
    end

    resp_meta_t meta_q [NumPorts][SramLatency];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned p = 0; p < NumPorts; p++) begin
                for (int unsigned s = 0; s < SramLatency; s++) begin
                    meta_q[p][s] <= '0;
                end
            end
        end else begin
            for (int unsigned p = 0; p < NumPorts; p++) begin
                meta_q[p][0] <= {gnt_o[p], we_i[p], port_bank[p], port_row[p]};
                for (int unsigned s = 1; s < SramLatency; s++) begin
                    meta_q[p][s] <= meta_q[p][s-1];
                end
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            rvalid_o[p] = meta_q[p][SramLatency-1].valid;
            if (meta_q[p][SramLatency-1].valid && !meta_q[p][SramLatency-1].we) begin
                rdata_o[p] = sram_rdata_q[meta_q[p][SramLatency-1].bank]
                                         [meta_q[p][SramLatency-1].row][SramLatency-1];
            end
        end
    end

`ifdef MEM_BANK_XBAR_CONFLICT_CNT_EN
    logic [NumBanks-1:0][31:0] conflict_cnt_q, conflict_cnt_d;
    logic [NumBanks-1:0][32:0] conflict_sum;

    // Adds (requesters - 1); with zero or one requester the counter is unchanged.
    always_comb begin
        conflict_sum   = '0;
        conflict_cnt_d = conflict_cnt_q;
        for (int unsigned b = 0; b < NumBanks; b++) begin
            conflict_sum[b] = {1'b0, conflict_cnt_q[b]} + 33'($countones(bank_req[b]));
            if (|bank_req[b]) conflict_sum[b] = conflict_sum[b] - 33'd1;
            conflict_cnt_d[b] = conflict_sum[b][32] ? '1 : conflict_sum[b][31:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mem_bank_xbar_sram.sv
// Randomized self-checking bench for mem_bank_xbar_sram against a flat-memory reference model.
module tb_mem_bank_xbar_sram;

    localparam int NP = 4;
    localparam int NB = 4;
    localparam int DW = 64;
    localparam int NW = 256;
    localparam int NR = 2;
    localparam int AW = 48;
    localparam int TotalWords = NB * NW * NR;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    rst3 = 1'b1;
    logic [NP-1:0]           req = '0;
    logic [NP-1:0]           req3 = '0;
    logic [NP-1:0]           gnt, gnt3;
    logic [NP-1:0]           we = '0;
    logic [NP-1:0][AW-1:0]   addr = '0;
    logic [NP-1:0][DW-1:0]   wdata = '0;
    logic [NP-1:0][DW/8-1:0] be = '0;
    logic [NP-1:0]           rvalid, rvalid3;
    logic [NP-1:0][DW-1:0]   rdata, rdata3;
`ifdef MEM_BANK_XBAR_CONFLICT_CNT_EN
    logic [NB-1:0][31:0]     conflict_cnt, conflict_cnt3;
`endif

    always #5 clk = ~clk;

    mem_bank_xbar_sram #(
        .NumPorts(NP), .NumBanks(NB), .DataWidth(DW), .SramNumWords(NW),
        .NumBankRows(NR), .SramLatency(1), .AddrWidth(AW)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid), .rdata_o(rdata)
`ifdef MEM_BANK_XBAR_CONFLICT_CNT_EN
        , .conflict_cnt_o(conflict_cnt)
`endif
    );

    mem_bank_xbar_sram #(
        .NumPorts(NP), .NumBanks(NB), .DataWidth(DW), .SramNumWords(NW),
        .NumBankRows(NR), .SramLatency(3), .AddrWidth(AW)
    ) u_dut_l3 (
        .clk_i(clk), .rst_i(rst3), .req_i(req3), .gnt_o(gnt3), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid3), .rdata_o(rdata3)
`ifdef MEM_BANK_XBAR_CONFLICT_CNT_EN
        , .conflict_cnt_o(conflict_cnt3)
`endif
    );

    int chk_cnt = 0;
    int pass_cnt = 0;

    // Reference model: one flat word array (addresses wrap modulo total capacity).
    logic [DW-1:0]         model_mem [TotalWords];
    int                    last_win [NB];
    logic [NP-1:0]         exp_rv;
    logic [NP-1:0][DW-1:0] exp_rd;
    logic [NP-1:0]         obs_gnt, obs_rv;
    logic [NP-1:0][DW-1:0] obs_rd;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    function automatic int flat(input logic [AW-1:0] a);
        return int'((a / (DW / 8)) % TotalWords);
    endfunction

    task automatic reset_model();
        for (int b = 0; b < NB; b++) last_win[b] = NP - 1;
        exp_rv = '0;
        exp_rd = '0;
    endtask

    task automatic set_idle();
        req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    endtask

    task automatic drive(input int p, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW/8-1:0] b);
        req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d; be[p] = b;
    endtask

    // One clock of the main DUT: predict grants, compare, then advance the model.
    task automatic cycle();
        logic [NP-1:0]         eg;
        logic [NP-1:0]         nrv;
        logic [NP-1:0][DW-1:0] nrd;
        int                    win, p, idx;
        @(negedge clk);
        eg = '0;
        for (int b = 0; b < NB; b++) begin
            win = -1;
            for (int k = 1; k <= NP; k++) begin
                p = (last_win[b] + k) % NP;
                if (win < 0 && req[p] && (flat(addr[p]) % NB) == b) win = p;
            end
            if (win >= 0) begin
                eg[win] = 1'b1;
                last_win[b] = win;
            end
        end
        obs_gnt = gnt; obs_rv = rvalid; obs_rd = rdata;
        for (int q = 0; q < NP; q++) begin
            check_eq($sformatf("gnt[%0d]", q), 64'(gnt[q]), 64'(eg[q]));
            check_eq($sformatf("rvalid[%0d]", q), 64'(rvalid[q]), 64'(exp_rv[q]));
            check_eq($sformatf("rdata[%0d]", q), rdata[q], exp_rd[q]);
        end
        for (int q = 0; q < NP; q++) begin
            idx = flat(addr[q]);
            nrv[q] = eg[q];
            nrd[q] = (eg[q] && !we[q]) ? model_mem[idx] : '0;
        end
        for (int q = 0; q < NP; q++) begin
            idx = flat(addr[q]);
            if (eg[q] && we[q]) begin
                for (int i = 0; i < DW / 8; i++) begin
                    if (be[q][i]) model_mem[idx][i*8 +: 8] = wdata[q][i*8 +: 8];
                end
            end
        end
        exp_rv = nrv;
        exp_rd = nrd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] r0, d3, got_d;
        logic [NP-1:0] pending;
        logic [AW-1:0] a;
        int            seen, lat, pulses;

        reset_model();
        set_idle();
        req = '1;
        req3 = '1;
        @(negedge clk);
        check_eq("reset_gnt", 64'(gnt), 64'd0);
        check_eq("reset_rvalid", 64'(rvalid), 64'd0);
        check_eq("reset_rdata0", rdata[0], 64'd0);
        check_eq("reset_gnt_l3", 64'(gnt3), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        set_idle();
        req3 = '0;
        rst = 1'b0;
        rst3 = 1'b0;

        // Prefill every word, with random high address bits to exercise aliasing.
        for (int k = 0; k < TotalWords / NP; k++) begin
            set_idle();
            for (int p = 0; p < NP; p++) begin
                a = AW'((NP * k + p) * (DW / 8)) | (AW'($urandom_range(0, 15)) << 20);
                drive(p, 1'b1, a, {$urandom, $urandom}, '1);
            end
            cycle();
        end
        set_idle();
        cycle();

        // Write then read back one word.
        drive(0, 1'b1, 48'h40, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        cycle();
        check_eq("t1_wr_gnt", 64'(obs_gnt[0]), 64'd1);
        set_idle();
        drive(0, 1'b0, 48'h40, '0, '0);
        cycle();
        set_idle();
        cycle();
        check_eq("t1_rvalid", 64'(obs_rv[0]), 64'd1);
        check_eq("t1_rdata", obs_rd[0], 64'hDEADBEEF_CAFEF00D);

        // Four ports, four different banks, same cycle.
        for (int p = 0; p < NP; p++) drive(p, 1'b0, AW'(p * 8), '0, '0);
        cycle();
        check_eq("t2_gnt", 64'(obs_gnt), 64'hF);
        set_idle();
        cycle();
        check_eq("t2_rvalid", 64'(obs_rv), 64'hF);

        // Partial byte-enable write to a row-1 word.
        r0 = model_mem[0];
        drive(0, 1'b1, 48'h2000, '1, 8'hFF);
        cycle();
        drive(0, 1'b1, 48'h2000, '0, 8'h0F);
        cycle();
        drive(0, 1'b0, 48'h2000, '0, '0);
        cycle();
        drive(0, 1'b0, 48'h0, '0, '0);
        cycle();
        check_eq("t4_be_rdata", obs_rd[0], 64'hFFFFFFFF_00000000);
        set_idle();
        cycle();
        check_eq("t4_row0_rdata", obs_rd[0], r0);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model();

`ifdef MEM_BANK_XBAR_CONFLICT_CNT_EN
        for (int p = 0; p < NP; p++) drive(p, 1'b0, AW'(16 + p * 32), '0, '0);
        cycle();
        for (int b = 0; b < NB; b++) begin
            check_eq($sformatf("conflict_cnt[%0d]", b), 64'(conflict_cnt[b]),
                     (b == 2) ? 64'd3 : 64'd0);
        end
        set_idle();
        cycle();
`endif

        // All ports contend for bank 0 and hold until served.
        pending = '1;
        for (int s = 0; s < NP; s++) begin
            set_idle();
            for (int p = 0; p < NP; p++) begin
                if (pending[p]) drive(p, 1'b0, AW'(p * 32), '0, '0);
            end
            cycle();
            check_eq($sformatf("t3_order%0d", s), 64'(obs_gnt), 64'(1) << s);
            pending[s] = 1'b0;
        end
        for (int p = 0; p < NP; p++) drive(p, 1'b0, AW'(p * 32), '0, '0);
        cycle();
        check_eq("t3_ptr_wrap", 64'(obs_gnt), 64'd1);
        set_idle();
        cycle();

        // Random traffic concentrated on few words so banks collide often.
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (!(req[p] && !obs_gnt[p])) begin
                    a = AW'({$urandom, $urandom});
                    a = (a & ~AW'(16'h3FF8)) | (AW'($urandom_range(0, 63)) << 3);
                    req[p]   = ($urandom_range(0, 3) != 0);
                    we[p]    = $urandom_range(0, 1) == 1;
                    addr[p]  = a;
                    wdata[p] = {$urandom, $urandom};
                    be[p]    = 8'($urandom);
                end
            end
            cycle();
        end
        set_idle();
        cycle();
        cycle();

        // Latency-3 instance: reset kills an in-flight read.
        d3 = 64'h0123_4567_89AB_CDEF;
        we[0] = 1'b1; addr[0] = 48'h100; wdata[0] = d3; be[0] = '1;
        req3 = 4'b0001;
        @(negedge clk);
        check_eq("l3_wr_gnt", 64'(gnt3), 64'd1);
        @(posedge clk);
        #1;
        req3 = '0;
        we[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        req3 = 4'b0001;
        @(posedge clk);
        #1;
        req3 = '0;
        @(posedge clk);
        #1;
        rst3 = 1'b1;
        req3 = '1;
        @(negedge clk);
        check_eq("l3_rst_gnt", 64'(gnt3), 64'd0);
        check_eq("l3_rst_rvalid", 64'(rvalid3), 64'd0);
        check_eq("l3_rst_rdata", rdata3[0], 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst3 = 1'b0;
        req3 = '0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rvalid3 != '0) seen++;
        end
        check_eq("l3_no_stale_resp", 64'(seen), 64'd0);

        @(posedge clk);
        #1;
        req3 = 4'b0001;
        @(negedge clk);
        check_eq("l3_rd_gnt", 64'(gnt3), 64'd1);
        @(posedge clk);
        #1;
        req3 = '0;
        lat = 0;
        pulses = 0;
        got_d = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (rvalid3[0]) begin
                pulses++;
                if (lat == 0) begin
                    lat = i;
                    got_d = rdata3[0];
                end
            end
        end
        check_eq("l3_latency", 64'(lat), 64'd3);
        check_eq("l3_pulses", 64'(pulses), 64'd1);
        check_eq("l3_rdata", got_d, d3);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
